// File: rtl/instr_issuer_pkg.sv
// Shared types and constants for the instruction issuer: state encoding,
// HALT opcode and the IR field positions used by the decoder.
package instr_issuer_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH     = 3'd1,
        LATCH     = 3'd2,
        ISSUE     = 3'd3,
        WAIT_ACK  = 3'd4,
        WAIT_DONE = 3'd5,
        HALTED    = 3'd6,
        ERR       = 3'd7
    } issuer_state_t;

    localparam logic [2:0] OPC_HALT = 3'b111;
    localparam int         OPC_MSB  = 15;
    localparam int         OPC_LSB  = 13;
    localparam int         OP_MSB   = 12;
    localparam int         OP_LSB   = 11;

    function automatic logic is_halt(input logic [15:0] instr);
        return (instr[OPC_MSB:OPC_LSB] == OPC_HALT);
    endfunction

endpackage

// File: rtl/issue_wdog.sv
// Hang watchdog: counts cycles while enabled, flags the terminal count on the
// DEPTH-th consecutive enabled cycle; clear has priority.
module issue_wdog #(
    parameter int DEPTH = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tc
);
    localparam int            CW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

    logic [CW-1:0] count_r;

    // Saturating up-counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= '0;
        end else if (clear) begin
            count_r <= '0;
        end else if (enable && (count_r != LAST)) begin
            count_r <= count_r + CW'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign tc = enable && (count_r == LAST);

endmodule

// File: rtl/instr_issuer.sv
// Instruction issuer: fetches from a synchronous memory at pc, latches the IR
// and runs the s/w start handshake with the controller, with HALT and a watchdog.
module instr_issuer
    import instr_issuer_pkg::*;
#(
    parameter int                ADDR_W      = 8,
    parameter logic [ADDR_W-1:0] START_ADDR  = '0,
    parameter int                WDOG_CYCLES = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic              stop,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [15:0]       mem_rdata,
    output logic [15:0]       ir,
    output logic              s,
    input  logic              w,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              halted,
    output logic              err,
    output logic [15:0]       issued_cnt
);
    issuer_state_t     state_r, next_state_s;
    logic [ADDR_W-1:0] pc_r;
    logic [15:0]       ir_r;
    logic [15:0]       cnt_r;
    logic              stop_lat_r;
    logic              s_r;
    logic              complete_s;
    logic              finish_s;
    logic              wdog_en_s;
    logic              wdog_clear_s;
    logic              wdog_tc_s;

    // run=0 mid-instruction acts like stop; both only matter at completion
    assign finish_s     = stop_lat_r | stop | ~run;
    assign wdog_en_s    = (state_r == WAIT_DONE);
    assign wdog_clear_s = ~wdog_en_s | w;

    issue_wdog #(.DEPTH(WDOG_CYCLES)) u_wdog (
        .clk    (clk),
        .rst    (reset),
        .clear  (wdog_clear_s),
        .enable (wdog_en_s),
        .tc     (wdog_tc_s)
    );

    // Next-state and instruction-completion decode
    always_comb begin
        next_state_s = state_r;
        complete_s   = 1'b0;
        case (state_r)
            IDLE:      next_state_s = run ? FETCH : IDLE;
            FETCH:     next_state_s = LATCH;
            LATCH:     next_state_s = is_halt(mem_rdata) ? HALTED : ISSUE;
            ISSUE:     next_state_s = s_r ? WAIT_ACK : ISSUE;
            WAIT_ACK: begin
                if (w) begin
                    complete_s   = 1'b1;
                    next_state_s = finish_s ? IDLE : FETCH;
                end else begin
                    next_state_s = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (w) begin
                    complete_s   = 1'b1;
                    next_state_s = finish_s ? IDLE : FETCH;
                end else if (wdog_tc_s) begin
                    next_state_s = ERR;
                end else begin
                    next_state_s = WAIT_DONE;
                end
            end
            HALTED:    next_state_s = run ? HALTED : IDLE;
            ERR:       next_state_s = ERR;
            default:   next_state_s = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // PC, IR, completion counter, stop latch and the registered start pulse.
    // s is raised for the ISSUE cycle only when w was high at the entering edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_r       <= START_ADDR;
            ir_r       <= 16'h0000;
            cnt_r      <= 16'h0000;
            stop_lat_r <= 1'b0;
            s_r        <= 1'b0;
        end else begin
            if (complete_s) begin
                pc_r <= pc_r + ADDR_W'(1);
            end else if ((state_r == HALTED) && !run) begin
                pc_r <= START_ADDR;
            end else begin
                pc_r <= pc_r;
            end
            if ((state_r == LATCH) && !is_halt(mem_rdata)) begin
                ir_r <= mem_rdata;
            end else begin
                ir_r <= ir_r;
            end
            if (complete_s) begin
                cnt_r <= cnt_r + 16'd1;
            end else begin
                cnt_r <= cnt_r;
            end
            if (next_state_s == IDLE) begin
                stop_lat_r <= 1'b0;
            end else if (stop) begin
                stop_lat_r <= 1'b1;
            end else begin
                stop_lat_r <= stop_lat_r;
            end
            s_r <= (next_state_s == ISSUE) && w;
        end
    end

    assign mem_addr   = pc_r;
    assign pc         = pc_r;
    assign mem_rd     = (state_r == FETCH);
    assign ir         = ir_r;
    assign s          = s_r;
    assign busy       = (state_r != IDLE) && (state_r != HALTED) && (state_r != ERR);
    assign halted     = (state_r == HALTED);
    assign err        = (state_r == ERR);
    assign issued_cnt = cnt_r;

endmodule

// File: tb/tb_instr_issuer.sv
// Self-checking bench for instr_issuer: transaction-level model of pc/count/err/halt
// checked every cycle, plus directed scenarios with literal expectations.
module tb_instr_issuer;
    localparam int          AW   = 3;
    localparam int          HANG = 1000000;
    localparam logic [15:0] ADD  = 16'h0801;
    localparam logic [15:0] MOV  = 16'h2802;
    localparam logic [15:0] HALT = 16'hE000;

    logic          clk       = 1'b0;
    logic          reset     = 1'b1;
    logic          run       = 1'b0;
    logic          stop      = 1'b0;
    logic          w         = 1'b1;
    logic [15:0]   mem_rdata = 16'h0000;
    logic [AW-1:0] mem_addr;
    logic [AW-1:0] pc;
    logic          mem_rd;
    logic          s;
    logic          busy;
    logic          halted;
    logic          err;
    logic [15:0]   ir;
    logic [15:0]   issued_cnt;

    logic [15:0]   mem [0:7];
    int            hold = 0;
    int            n_pass = 0;
    int            n_total = 0;

    int            ctl_left = 0;
    bit            ctl_pend = 1'b0;

    logic [AW-1:0] m_pc = '0;
    logic [15:0]   m_cnt = 16'h0000;
    bit            m_err = 1'b0;
    bit            m_halted = 1'b0;
    bit            pend = 1'b0;
    bit            prev_s = 1'b0;
    int            age = 0;
    int            lows = 0;
    int            fstage = 0;
    int            n_s = 0;

    int            ft [10];
    logic [AW-1:0] fa [10];
    int            nf;
    int            nrd;
    bit            seen;

    instr_issuer #(.ADDR_W(AW), .START_ADDR(3'd0), .WDOG_CYCLES(64)) dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .stop       (stop),
        .mem_addr   (mem_addr),
        .mem_rd     (mem_rd),
        .mem_rdata  (mem_rdata),
        .ir         (ir),
        .s          (s),
        .w          (w),
        .pc         (pc),
        .busy       (busy),
        .halted     (halted),
        .err        (err),
        .issued_cnt (issued_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    endtask

    // synchronous instruction memory
    always @(posedge clk) begin
        if (mem_rd) mem_rdata <= mem[mem_addr];
    end

    // controller: after seeing s, drops w for 'hold' cycles (hold=0 -> 1-cycle op)
    always @(negedge clk) begin
        if (reset) begin
            ctl_left = 0;
            ctl_pend = 1'b0;
            w = 1'b1;
        end else begin
            if (ctl_pend) begin
                ctl_pend = 1'b0;
                ctl_left = hold;
            end else if (ctl_left > 0) begin
                ctl_left--;
            end
            if (s) ctl_pend = 1'b1;
            w = (ctl_left == 0);
        end
    end

    // behavioural model and per-cycle comparison, sampled just after each edge
    always @(posedge clk) begin
        #1;
        if (reset) begin
            m_pc = '0; m_cnt = 16'h0000; m_err = 1'b0; m_halted = 1'b0;
            pend = 1'b0; prev_s = 1'b0; age = 0; lows = 0; fstage = 0; n_s = 0;
        end else begin
            if (m_halted && !run) begin
                m_halted = 1'b0;
                m_pc = '0;
            end
            if (fstage == 2) begin
                if (mem[m_pc][15:13] == 3'b111) m_halted = 1'b1;
                fstage = 0;
            end else if (fstage == 1) begin
                fstage = 2;
            end
            if (mem_rd) fstage = 1;
            if (pend) begin
                age++;
                if (age >= 2) begin
                    if (w) begin
                        m_cnt = m_cnt + 16'd1;
                        m_pc = m_pc + 3'd1;
                        pend = 1'b0;
                    end else begin
                        lows++;
                        if (lows == 65) begin
                            m_err = 1'b1;
                            pend = 1'b0;
                        end
                    end
                end
            end
            if (s) begin
                n_s++;
                chk("s_one_cycle", prev_s, 1'b0);
                chk("ir_on_issue", ir, mem[m_pc]);
                pend = 1'b1; age = 0; lows = 0;
            end
            prev_s = s;
            chk("pc", pc, m_pc);
            chk("mem_addr", mem_addr, m_pc);
            chk("issued_cnt", issued_cnt, m_cnt);
            chk("err", err, m_err);
            chk("halted", halted, m_halted);
        end
    end

    task automatic do_reset();
        @(negedge clk);
        run = 1'b0; stop = 1'b0; reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) mem[i] = 16'h0800 + 16'(i);

        // reset state
        @(negedge clk);
        chk("rst_mem_addr", mem_addr, 3'd0);
        chk("rst_pc", pc, 3'd0);
        chk("rst_ir", ir, 16'h0);
        chk("rst_cnt", issued_cnt, 16'h0);
        chk("rst_outs", {s, mem_rd, busy, halted, err}, 5'b0);
        reset = 1'b0;

        // 1: ADD, MOV, HALT with 3-cycle ops
        mem[0] = ADD; mem[1] = MOV; mem[2] = HALT;
        hold = 3;
        @(negedge clk); run = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin @(negedge clk); seen = halted; end
        chk("t1_halted", halted, 1'b1);
        chk("t1_s_pulses", n_s, 2);
        chk("t1_cnt", issued_cnt, 16'd2);
        chk("t1_pc", pc, 3'd2);
        chk("t1_ir_kept", ir, MOV);
        chk("t1_busy", busy, 1'b0);
        run = 1'b0;
        @(negedge clk); @(negedge clk);
        chk("t1_unhalt", halted, 1'b0);
        chk("t1_pc_restart", pc, 3'd0);

        // 2: async reset in WAIT_DONE of the second instruction
        do_reset();
        run = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin @(negedge clk); seen = (n_s == 2); end
        chk("t2_second_issue", seen, 1'b1);
        @(negedge clk); @(negedge clk);
        chk("t2_pre_cnt", issued_cnt, 16'd1);
        chk("t2_pre_ir", ir, MOV);
        reset = 1'b1;
        #1;
        chk("t2_s", s, 1'b0);
        chk("t2_pc", pc, 3'd0);
        chk("t2_ir", ir, 16'h0);
        chk("t2_cnt", issued_cnt, 16'h0);
        chk("t2_idle", {busy, mem_rd, err}, 3'b0);
        @(negedge clk);
        run = 1'b0; reset = 1'b0;

        // 3+6: 1-cycle ops, 4-cycle throughput, pc wrap 7 -> 0
        for (int i = 0; i < 8; i++) mem[i] = 16'h0800 + 16'(i);
        hold = 0;
        do_reset();
        run = 1'b1;
        nf = 0;
        for (int cyc = 0; cyc < 120 && nf < 10; cyc++) begin
            @(negedge clk);
            if (mem_rd) begin ft[nf] = cyc; fa[nf] = mem_addr; nf++; end
        end
        chk("t3_fetch_count", nf, 10);
        for (int k = 0; k < 3; k++) chk("t3_fetch_spacing", ft[k+1] - ft[k], 4);
        chk("t6_addr7", fa[7], 3'd7);
        chk("t6_wrap_addr0", fa[8], 3'd0);
        run = 1'b0;

        // 4: stop during ISSUE of the instruction at address 5
        hold = 3;
        do_reset();
        run = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin @(negedge clk); seen = s && (pc == 3'd5); end
        chk("t4_issue_at5", seen, 1'b1);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin @(negedge clk); seen = !busy; end
        chk("t4_idle", seen, 1'b1);
        run = 1'b0;
        chk("t4_pc", pc, 3'd6);
        chk("t4_cnt", issued_cnt, 16'd6);
        nrd = 0;
        for (int i = 0; i < 10; i++) begin @(negedge clk); if (mem_rd) nrd++; end
        chk("t4_no_fetch", nrd, 0);

        // 5: controller hangs -> watchdog error, sticky until reset
        hold = HANG;
        do_reset();
        run = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin @(negedge clk); seen = s; end
        chk("t5_issue", seen, 1'b1);
        for (int i = 1; i <= 66; i++) begin
            @(negedge clk);
            if (i == 65) chk("t5_err_not_yet", err, 1'b0);
            if (i == 66) chk("t5_err_fired", err, 1'b1);
        end
        chk("t5_err_quiet", {busy, s, mem_rd}, 3'b0);
        for (int i = 0; i < 20; i++) begin @(negedge clk); run = i[0]; end
        chk("t5_err_sticky", err, 1'b1);
        reset = 1'b1;
        #1;
        chk("t5_err_cleared", err, 1'b0);
        @(negedge clk);
        reset = 1'b0; run = 1'b0; hold = 0;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
